// File: rtl/fft_pkg.sv
// Shared types and default sizes for the FFT ping-pong capture path.
// The FFT read side reuses the same constants.
package fft_pkg;

    localparam int FFT_AWIDTH = 7;
    localparam int FFT_DWIDTH = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2,
        BUSY    = 2'd3
    } bank_state_e;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

endpackage

// File: rtl/fft_bank_tracker.sv
// Lifecycle of one RAM bank: EMPTY -> FILLING -> FULL -> BUSY -> EMPTY.
// A request is honoured only from the state that precedes it in that cycle.
module fft_bank_tracker
    import fft_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        set_filling,
    input  logic        set_full,
    input  logic        set_busy,
    input  logic        release_bank,
    output bank_state_e state
);

    bank_state_e state_q;
    bank_state_e state_d;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (set_filling)  state_d = FILLING;
            FILLING: if (set_full)     state_d = FULL;
            FULL:    if (set_busy)     state_d = BUSY;
            BUSY:    if (release_bank) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/fft_pingpong_ctrl.sv
// Ping-pong capture controller: writes sample frames into one RAM bank while the
// FFT owns the other, handing full banks to the FFT in strict 0,1,0,... order.
module fft_pingpong_ctrl
    import fft_pkg::*;
#(
    parameter int AWIDTH = FFT_AWIDTH,
    parameter int DWIDTH = FFT_DWIDTH
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                en_in,
    input  logic                data_vld,
    input  logic [DWIDTH/2-1:0] im_d,
    input  logic [DWIDTH/2-1:0] re_d,
    output logic                wr_en,
    output logic                wr_we,
    output logic [AWIDTH:0]     wr_addr,
    output logic [DWIDTH-1:0]   wr_d,
    output logic                rd_start,
    output logic                rd_bank,
    input  logic                rd_done,
    output logic                ready_out,
    output logic                drop_err
);

    bank_state_e       bank_st [2];
    logic [1:0]        set_filling;
    logic [1:0]        set_full;
    logic [1:0]        set_busy;
    logic [1:0]        release_bank;

    wr_state_e         wr_state_q, wr_state_d;
    logic              wr_bank_q, wr_bank_d;
    logic [AWIDTH-1:0] cnt_q, cnt_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic              rd_bank_q, rd_bank_d;
    logic              rd_active_q, rd_active_d;
    logic              rd_start_q, rd_start_d;
    logic              bank_free;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        fft_bank_tracker u_bank (
            .clk          (clk_in),
            .rst_n        (rst_n_in),
            .set_filling  (set_filling[b]),
            .set_full     (set_full[b]),
            .set_busy     (set_busy[b]),
            .release_bank (release_bank[b]),
            .state        (bank_st[b])
        );
    end

    // Frame handshake: a frame starts in the cycle en_in && ready_out; en_in while
    // ready_out=0 has no effect and is not remembered. Samples in that cycle are dropped.
    assign bank_free = (bank_st[wr_bank_q] == EMPTY);

    always_comb begin
        wr_state_d  = wr_state_q;
        wr_bank_d   = wr_bank_q;
        cnt_d       = cnt_q;
        set_filling = '0;
        set_full    = '0;
        ready_out   = 1'b0;
        wr_en       = 1'b0;
        drop_err    = 1'b0;
        unique case (wr_state_q)
            IDLE: begin
                ready_out = bank_free;
                drop_err  = data_vld;
                if (en_in && bank_free) begin
                    wr_state_d             = WRITE;
                    set_filling[wr_bank_q] = 1'b1;
                    cnt_d                  = '0;
                end
            end
            WRITE: begin
                wr_en = data_vld;
                if (data_vld) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == '1) begin
                        set_full[wr_bank_q] = 1'b1;
                        wr_bank_d           = ~wr_bank_q;
                        wr_state_d          = IDLE;
                    end
                end
            end
            default: wr_state_d = IDLE;
        endcase
    end

    // Read scheduler: one bank outstanding at a time; rd_bank_q pins the handed bank.
    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        rd_bank_d    = rd_bank_q;
        rd_active_d  = rd_active_q;
        rd_start_d   = 1'b0;
        set_busy     = '0;
        release_bank = '0;
        if (!rd_active_q) begin
            if (bank_st[rd_ptr_q] == FULL) begin
                rd_start_d         = 1'b1;
                rd_active_d        = 1'b1;
                rd_bank_d          = rd_ptr_q;
                set_busy[rd_ptr_q] = 1'b1;
            end
        end else if (rd_done && bank_st[rd_bank_q] == BUSY) begin
            release_bank[rd_bank_q] = 1'b1;
            rd_ptr_d                = ~rd_ptr_q;
            rd_active_d             = 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_state_q  <= IDLE;
            wr_bank_q   <= 1'b0;
            cnt_q       <= '0;
            rd_ptr_q    <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_active_q <= 1'b0;
            rd_start_q  <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            wr_bank_q   <= wr_bank_d;
            cnt_q       <= cnt_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_bank_q   <= rd_bank_d;
            rd_active_q <= rd_active_d;
            rd_start_q  <= rd_start_d;
        end
    end

    assign wr_we    = wr_en;
    assign wr_addr  = {wr_bank_q, cnt_q};
    assign wr_d     = {im_d, re_d};
    assign rd_start = rd_start_q;
    assign rd_bank  = rd_bank_q;

endmodule
